// File: rtl/router_pkg.sv
// Shared definitions for the router output stage: packet geometry and arbiter state encoding.
package router_pkg;

    localparam int PKT_W   = 35;
    localparam int ADDR_W  = 8;
    localparam int ADDR_HI = PKT_W - 1;
    localparam int ADDR_LO = PKT_W - ADDR_W;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin priority search: first set request strictly after ptr, wrapping modulo NREQ.
module rr_priority_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    int cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = 0;
        // ptr itself is scanned last, so the previous winner has lowest priority.
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(ptr_i) + k) % NREQ;
            if (!any_o && req_i[cand]) begin
                any_o         = 1'b1;
                idx_o         = IDX_W'(cand);
                grant_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/router_out_arbiter.sv
// Output-port arbiter: round-robin selects one of NREQ input directions into a
// single registered output slot that can reload on the same edge it drains.
module router_out_arbiter
    import router_pkg::*;
#(
    parameter int WIDTH = PKT_W,
    parameter int NREQ  = 4,
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    input  logic                  out_ready,
    output logic [IDX_W-1:0]      grant_id,
    output logic [15:0]           pkt_count
);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  data_q;
    logic [IDX_W-1:0]  gid_q;
    logic [IDX_W-1:0]  ptr_q;
    logic [15:0]       cnt_q;

    logic [NREQ-1:0]   pick_grant;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic              load;
    logic              accept;
    logic              xfer;

    rr_priority_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    assign xfer   = (state_q == SEND) && out_ready;
    // rst gating keeps req_ready low while reset is held, even though state reads IDLE.
    assign load   = !rst && ((state_q == IDLE) || xfer);
    assign accept = load && pick_any;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SEND;
            SEND:    if (xfer)   state_d = accept ? SEND : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_q == SEND);
        req_ready = load ? pick_grant : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            gid_q  <= '0;
            ptr_q  <= IDX_W'(NREQ - 1);
        end else if (accept) begin
            data_q <= req_data[int'(pick_idx)*WIDTH +: WIDTH];
            gid_q  <= pick_idx;
            ptr_q  <= pick_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (xfer) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign out_data  = data_q;
    assign grant_id  = gid_q;
    assign pkt_count = cnt_q;

endmodule
